// File: rtl/resource_arbiter.sv
// -----------------------------------------------------------------------------
// resource_arbiter
//   Shares one downstream resource between N requesters. Grants are registered
//   and sticky: the owner keeps the resource until it drops its request or its
//   hold budget (MAX_HOLD cycles) runs out while somebody else is waiting.
//
//   Winner selection:
//     default              : highest asserted index wins.
//     ARB_ROUND_ROBIN_EN   : (compile-time macro) rotating priority, the search
//                            starts one past the last winner and wraps.
//
//   Handshake: req[i] is a level. It is held high for as long as requester i
//   wants or uses the resource; gnt[i] high means requester i owns it. A grant
//   changes only on a rising clk edge, and there is no combinational path from
//   req to any output.
//
// Ports
//   clk        in   1          rising-edge clock
//   rst_n      in   1          asynchronous active-low reset
//   req        in   N          request vector
//   gnt        out  N          one-hot grant, zero when idle
//   gnt_id     out  IDW        index of the owner, zero when idle
//   gnt_valid  out  1          OR of gnt
//   hold_cnt   out  HCW        cycles elapsed in the current ownership
// -----------------------------------------------------------------------------
module resource_arbiter #(
  parameter  int N        = 4,
  parameter  int MAX_HOLD = 8,
  localparam int IDW      = (N > 1) ? $clog2(N) : 1,
  localparam int HCW      = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_id,
  output logic           gnt_valid,
  output logic [HCW-1:0] hold_cnt
);

  typedef enum logic {IDLE, OWNED} state_t;
  state_t state;

`ifdef ARB_ROUND_ROBIN_EN
  logic [IDW-1:0] last_id;
`endif

  // Candidates for a new grant: everyone when idle, everyone except the
  // current owner otherwise (the owner is never re-granted by arbitration;
  // retaining on expiry is handled separately).
  logic [N-1:0]   cand;
  logic           win_found;
  logic [IDW-1:0] win_id;

  always_comb begin
    cand      = (state == IDLE) ? req : (req & ~gnt);
    win_found = |cand;
    win_id    = '0;
`ifdef ARB_ROUND_ROBIN_EN
    // Walk offsets from farthest to nearest so the nearest asserted index
    // after last_id is the final (winning) assignment.
    for (int o = N; o >= 1; o--) begin
      if (cand[(int'(last_id) + o) % N]) win_id = IDW'((int'(last_id) + o) % N);
    end
`else
    // Ascending scan: the highest asserted index is assigned last and wins.
    for (int i = 0; i < N; i++) begin
      if (cand[i]) win_id = IDW'(i);
    end
`endif
  end

  logic owner_req;
  logic expired;
  logic arb_now;

  always_comb begin
    owner_req = req[gnt_id];
    expired   = (MAX_HOLD != 0) && (hold_cnt == HCW'(MAX_HOLD));
    arb_now   = (state == IDLE) || !owner_req || expired;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      gnt       <= '0;
      gnt_id    <= '0;
      gnt_valid <= 1'b0;
      hold_cnt  <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_id   <= IDW'(N - 1);
`endif
    end else if (arb_now && win_found) begin
      // New grant from idle, on release, or as a handover on expiry.
      state       <= OWNED;
      gnt         <= '0;
      gnt[win_id] <= 1'b1;
      gnt_id      <= win_id;
      gnt_valid   <= 1'b1;
      hold_cnt    <= HCW'(1);
`ifdef ARB_ROUND_ROBIN_EN
      last_id     <= win_id;
`endif
    end else if (state == OWNED) begin
      if (!owner_req) begin
        // Released with nobody else waiting.
        state     <= IDLE;
        gnt       <= '0;
        gnt_id    <= '0;
        gnt_valid <= 1'b0;
        hold_cnt  <= '0;
      end else if (expired) begin
        // Budget ran out but nobody else wants it: owner keeps it, new window.
        hold_cnt <= HCW'(1);
      end else if (MAX_HOLD != 0) begin
        hold_cnt <= hold_cnt + HCW'(1);
      end else begin
        hold_cnt <= HCW'(1);
      end
    end
  end

endmodule

// File: tb/tb_resource_arbiter.sv
// -----------------------------------------------------------------------------
// tb_resource_arbiter
//   Three arbiters (MAX_HOLD = 8, 2, 0) share one request vector. A queue-free
//   behavioural model (owner index, hold count, last winner per instance)
//   predicts every output each cycle; a few literal expectations pin the model.
// -----------------------------------------------------------------------------
module tb_resource_arbiter;

  localparam int N = 4;
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0] req = '0;
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  logic [N-1:0] d_gnt [3];
  logic [1:0]   d_id  [3];
  logic         d_vld [3];
  logic [3:0]   hold_a;
  logic [1:0]   hold_b;
  logic [0:0]   hold_c;

  resource_arbiter #(.N(N), .MAX_HOLD(8)) u_a (
    .clk(clk), .rst_n(rst_n), .req(req), .gnt(d_gnt[0]), .gnt_id(d_id[0]),
    .gnt_valid(d_vld[0]), .hold_cnt(hold_a));
  resource_arbiter #(.N(N), .MAX_HOLD(2)) u_b (
    .clk(clk), .rst_n(rst_n), .req(req), .gnt(d_gnt[1]), .gnt_id(d_id[1]),
    .gnt_valid(d_vld[1]), .hold_cnt(hold_b));
  resource_arbiter #(.N(N), .MAX_HOLD(0)) u_c (
    .clk(clk), .rst_n(rst_n), .req(req), .gnt(d_gnt[2]), .gnt_id(d_id[2]),
    .gnt_valid(d_vld[2]), .hold_cnt(hold_c));

  // ---------------- model ----------------
  int mh      [3] = '{8, 2, 0};
  int m_owner [3];
  int m_hold  [3];
  int m_last  [3];

  int n_vec = 0;
  int n_cmp = 0;
  int n_err = 0;

  function automatic int pick(logic [N-1:0] c, int last);
    if (RR) begin
      for (int o = 1; o <= N; o++) if (c[(last + o) % N]) return (last + o) % N;
    end else begin
      for (int i = N - 1; i >= 0; i--) if (c[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int u = 0; u < 3; u++) begin
      m_owner[u] = -1;
      m_hold[u]  = 0;
      m_last[u]  = N - 1;
    end
  endtask

  task automatic model_step();
    for (int u = 0; u < 3; u++) begin
      int w;
      if (m_owner[u] < 0) begin
        w = pick(req, m_last[u]);
        if (w >= 0) begin m_owner[u] = w; m_hold[u] = 1; m_last[u] = w; end
      end else begin
        logic [N-1:0] others;
        others = req;
        others[m_owner[u]] = 1'b0;
        w = pick(others, m_last[u]);
        if (!req[m_owner[u]]) begin
          if (w >= 0) begin m_owner[u] = w; m_hold[u] = 1; m_last[u] = w; end
          else begin m_owner[u] = -1; m_hold[u] = 0; end
        end else if (mh[u] != 0 && m_hold[u] == mh[u]) begin
          if (w >= 0) begin m_owner[u] = w; m_last[u] = w; end
          m_hold[u] = 1;
        end else begin
          m_hold[u] = (mh[u] == 0) ? 1 : m_hold[u] + 1;
        end
      end
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    for (int u = 0; u < 3; u++) begin
      int eg, eh;
      eg = (m_owner[u] >= 0) ? (1 << m_owner[u]) : 0;
      eh = (u == 0) ? int'(hold_a) : (u == 1) ? int'(hold_b) : int'(hold_c);
      chk($sformatf("u%0d gnt", u), int'(d_gnt[u]), eg);
      chk($sformatf("u%0d gnt_id", u), int'(d_id[u]), (m_owner[u] >= 0) ? m_owner[u] : 0);
      chk($sformatf("u%0d gnt_valid", u), int'(d_vld[u]), (m_owner[u] >= 0) ? 1 : 0);
      chk($sformatf("u%0d hold_cnt", u), eh, m_hold[u]);
    end
  endtask

  // One clock of stimulus: model advances on the edge, outputs compared at negedge.
  task automatic cycle();
    n_vec++;
    @(posedge clk);
    if (rst_n) model_step();
    @(negedge clk);
    compare_all();
  endtask

  // ---------------- driver ----------------
  initial begin
    model_reset();
    req   = '0;
    rst_n = 1'b0;
    repeat (2) cycle();
    rst_n = 1'b1;

    // Idle with no requests.
    repeat (5) begin
      cycle();
      chk("idle gnt", int'(d_gnt[0]), 0);
      chk("idle gnt_valid", int'(d_vld[0]), 0);
    end

    // First grant from idle.
    req = 4'b0110;
    cycle();
    chk("first gnt", int'(d_gnt[0]), RR ? 2 : 4);
    chk("first gnt_id", int'(d_id[0]), RR ? 1 : 2);

    // Expiry handover: id 3 owns exactly 8 cycles, then 0 with no gap.
    req = 4'b0000;
    cycle();
    req = 4'b1001;
    for (int i = 1; i <= 9; i++) begin
      cycle();
      chk($sformatf("expiry gnt c%0d", i), int'(d_gnt[0]), (i <= 8) ? 8 : 1);
      chk($sformatf("expiry valid c%0d", i), int'(d_vld[0]), 1);
    end

    // Lone requester: retains, hold_cnt wraps 8 -> 1.
    req = 4'b0000;
    cycle();
    req = 4'b1000;
    for (int i = 1; i <= 10; i++) begin
      cycle();
      chk($sformatf("retain gnt c%0d", i), int'(d_gnt[0]), 8);
      chk($sformatf("retain hold c%0d", i), int'(hold_a), ((i - 1) % 8) + 1);
    end

    // Release handover 2 -> 0 in one edge.
    req = 4'b0000;
    cycle();
    req = 4'b0100;
    cycle();
    chk("rel own2", int'(d_gnt[0]), 4);
    req = 4'b0101;
    cycle();
    chk("rel sticky", int'(d_gnt[0]), 4);
    req = 4'b0001;
    cycle();
    chk("rel gnt", int'(d_gnt[0]), 1);
    chk("rel valid", int'(d_vld[0]), 1);

    // Asynchronous reset mid-ownership.
    req = 4'b0000;
    cycle();
    req = 4'b1000;
    cycle();
    chk("pre-reset gnt", int'(d_gnt[0]), 8);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("async reset gnt", int'(d_gnt[0]), 0);
    chk("async reset valid", int'(d_vld[0]), 0);
    req = 4'b1111;
    cycle();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (i == 0) chk("post-reset gnt", int'(d_gnt[0]), RR ? 1 : 8);
      chk($sformatf("hold2 seq c%0d", i), int'(d_id[1]),
          RR ? (i / 2) % 4 : (((i / 2) % 2 == 0) ? 3 : 2));
    end

    // Randomized traffic with occasional resets.
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 99) < 2) begin
        rst_n = 1'b0;
        model_reset();
        cycle();
        rst_n = 1'b1;
      end else begin
        case ($urandom_range(0, 7))
          0, 1:    req = 4'($urandom_range(0, 15));
          2:       req = req & 4'($urandom_range(0, 15));
          3:       req = '0;
          default: ;
        endcase
        cycle();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/resource_arbiter.md
Name: resource_arbiter

Overview:
- Sequential N-way arbiter that shares a single downstream resource between N requesters.
- Grants are registered and sticky: the owner holds the resource until it drops its request or its hold budget expires.
- Winner selection uses the team's priority-encoding scheme: the highest index wins by default, with optional round-robin rotation.
- Sits between requester agents and the shared datapath and drives that datapath's select/enable.

Parameters:
- N, 4, number of requesters (2..16).
- MAX_HOLD, 8, maximum consecutive grant cycles per ownership; 0 = unlimited.
- IDW, $clog2(N), derived width of the grant index; not overridden.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  N  request vector; req[i] is held high while requester i wants or uses the resource.
- gnt  output  N  one-hot grant, registered; all zero when idle.
- gnt_id  output  IDW  index of the current owner; 0 when idle.
- gnt_valid  output  1  high when any grant is active, i.e. the OR of gnt.
- hold_cnt  output  $clog2(MAX_HOLD+1) (min 1)  cycles elapsed in the current ownership.

Behaviour:
- Reset (async assert, sync-safe release):
  - gnt=0, gnt_id=0, gnt_valid=0, hold_cnt=0.
  - FSM enters IDLE.
  - Round-robin pointer last_id=N-1.
- FSM states: IDLE, OWNED.
- IDLE:
  - If req != 0 at a rising edge: at that edge gnt/gnt_id/gnt_valid are loaded for the winner, hold_cnt=1, state -> OWNED.
  - Latency is one cycle from req sampled to gnt visible.
  - If req == 0: remain in IDLE, outputs stay zero.
- OWNED, owner k:
  - req[k]=1 and (MAX_HOLD==0 or hold_cnt<MAX_HOLD): keep the grant; hold_cnt increments; saturate at MAX_HOLD when MAX_HOLD==0 is not the case; with MAX_HOLD==0 hold_cnt holds at 1.
  - req[k]=0 (release): at that edge, arbitrate among req excluding k.
    - Winner exists: new grant with no idle bubble, hold_cnt=1.
    - No winner: gnt=0, state -> IDLE.
  - req[k]=1 and hold_cnt==MAX_HOLD (expiry): arbitrate among req excluding k.
    - Winner exists: hand over at this edge, hold_cnt=1.
    - No winner: k retains the grant, hold_cnt restarts at 1.
    - Owner gnt is therefore high for at most MAX_HOLD cycles while others wait.
- Winner selection:
  - Fixed priority: highest asserted index wins (req 4'b1010 -> id 3).
- Invariants:
  - gnt is always one-hot or zero.
  - gnt_id == position of the set bit in gnt.
  - gnt_valid == |gnt.
- Request changes:
  - Non-owner req changes never affect the current grant before release or expiry.
  - A req pulse shorter than one cycle between edges is not seen.
- Reset mid-ownership: gnt drops immediately (asynchronously); the first grant after reset follows the reset pointer.
- Outputs are purely registered; there is no combinational path from req to gnt.

Optional Feature:
- Macro ARB_ROUND_ROBIN_EN.
- Defined:
  - Rotating priority: the search starts at last_id+1 modulo N, ascending with wrap.
  - The first asserted index found wins.
  - last_id updates to the winner on every new grant (including handover); it does not update on an owner-retains expiry.
  - After reset, index 0 has highest priority.
- Undefined:
  - Fixed highest-index priority.
  - last_id is absent and no pointer logic is synthesised.

Test Plan:
- Reset then req=4'b0000 for 5 cycles -> gnt=0, gnt_valid=0, gnt_id=0 throughout.
- req=4'b0110 from cycle 0, held -> gnt=4'b0100, gnt_id=2 at cycle 1 (fixed mode); with ARB_ROUND_ROBIN_EN: gnt=4'b0010, gnt_id=1.
- MAX_HOLD=8, req=4'b1001 held -> id 3 owns for exactly 8 cycles, then gnt=4'b0001 on the next cycle with no zero-gnt gap; with only req[3] high, gnt stays 4'b1000 and hold_cnt wraps 8->1.
- Owner id 2 drops req[2] while req[0]=1 -> gnt switches 4'b0100->4'b0001 in one edge, gnt_valid never low.
- rst_n asserted mid-ownership (gnt=4'b1000) -> gnt=0 immediately without a clock; after release with req=4'b1111 the first gnt=4'b1000 (fixed) or 4'b0001 (round-robin).
- ARB_ROUND_ROBIN_EN, req=4'b1111 held, MAX_HOLD=2 -> owner sequence 0,1,2,3,0, each for 2 cycles.
